// File: rtl/che_cmf_ipl_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : che_cmf_ipl_ctrl_pkg
// Description : Shared constants for the CMF interpolator sequencer: default
//               tile geometry, pixel width, log2 helper and FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package che_cmf_ipl_ctrl_pkg;

    // Default geometry: 4x4 tiles of 64x64 pixels, 8-bit pixels
    localparam int c_tile_siz   = 64;
    localparam int c_tile_num_x = 4;
    localparam int c_tile_num_y = 4;
    localparam int c_dat_pix_wd = 8;

    // Sequencer FSM encoding
    localparam int                c_st_w     = 2;
    localparam logic [c_st_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_st_w-1:0] c_st_run   = 2'd1;
    localparam logic [c_st_w-1:0] c_st_drain = 2'd2;
    localparam logic [c_st_w-1:0] c_st_done  = 2'd3;

    // Cycles spent in DRAIN so frame_done lands on the last pixel's
    // interpolator output
    localparam int c_drain_cyc = 3;

    // Ceiling log2, never below 1 so a single-tile axis still gets a
    // one-bit index field
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/che_cmf_axis_map.sv
`default_nettype none
// ============================================================================
// Module      : che_cmf_axis_map
// Description : Combinational coordinate-to-tile mapper for one image axis.
//               Pixels in the outer half-tile band map to a single edge tile
//               with zero offset; interior pixels are shifted by half a tile
//               and map to the tile pair (tile, tile+1) with in-tile offset.
// Revision    : 1.0 - initial release
// Ports       : i_coord    - pixel coordinate on this axis
//               o_tile     - first (left/up) tile index
//               o_off      - in-tile offset, 0 at the image border bands
//               o_pair_vld - high when the neighbouring tile is also used
// ============================================================================
module che_cmf_axis_map
    import che_cmf_ipl_ctrl_pkg::*;
#(
    parameter int TILE_SIZ = c_tile_siz,
    parameter int TILE_NUM = c_tile_num_x,
    parameter int CW       = clog2_min1(TILE_NUM * TILE_SIZ),
    parameter int TIW      = clog2_min1(TILE_NUM),
    parameter int TW       = clog2_min1(TILE_SIZ)
) (
    input  logic [CW-1:0]  i_coord,
    output logic [TIW-1:0] o_tile,
    output logic [TW-1:0]  o_off,
    output logic           o_pair_vld
);

    localparam int c_half = TILE_SIZ / 2;
    localparam int c_span = TILE_NUM * TILE_SIZ;

    logic [CW-1:0] w_xs;

    always_comb begin
        w_xs       = i_coord - CW'(c_half);
        o_tile     = '0;
        o_off      = '0;
        o_pair_vld = 1'b0;
        if (i_coord < CW'(c_half)) begin
            // leading border band: first tile only
            o_tile = '0;
        end else if (i_coord >= CW'(c_span - c_half)) begin
            // trailing border band: last tile only
            o_tile = TIW'(TILE_NUM - 1);
        end else begin
            o_tile     = TIW'(w_xs >> TW);
            o_off      = w_xs[TW-1:0];
            o_pair_vld = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/che_cmf_ipl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : che_cmf_ipl_ctrl
// Description : Pixel-stream sequencer for the CMF bilinear interpolator.
//               Tracks raster coordinates, issues the four tile-LUT reads per
//               accepted pixel and presents the interpolator valids/offsets
//               aligned with the returning LUT data.
// Revision    : 1.0 - initial release
// Ports       : clk, rst             - clock, async active-high reset
//               start_i              - frame start pulse (IDLE only)
//               pix_vld_i/pix_dat_i  - raster pixel input
//               pix_rdy_o            - pixel ready (RUN only)
//               lut_rd_o, lut_*_adr_o- LUT read strobe and {tile, pixel} addrs
//               *_vld_o, pos_x_o     - interpolator valids and x offset (n+2)
//               pos_y_o              - interpolator y offset (n+3)
//               busy_o, frame_done_o - frame progress
// ============================================================================
module che_cmf_ipl_ctrl
    import che_cmf_ipl_ctrl_pkg::*;
#(
    parameter  int TILE_SIZ   = c_tile_siz,
    parameter  int TILE_NUM_X = c_tile_num_x,
    parameter  int TILE_NUM_Y = c_tile_num_y,
    parameter  int DAT_PIX_WD = c_dat_pix_wd,
    localparam int TW         = clog2_min1(TILE_SIZ),
    localparam int AW         = clog2_min1(TILE_NUM_X * TILE_NUM_Y) + DAT_PIX_WD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  pix_vld_i,
    input  logic [DAT_PIX_WD-1:0] pix_dat_i,
    output logic                  pix_rdy_o,
    output logic                  lut_rd_o,
    output logic [AW-1:0]         lut_ul_adr_o,
    output logic [AW-1:0]         lut_ur_adr_o,
    output logic [AW-1:0]         lut_bl_adr_o,
    output logic [AW-1:0]         lut_br_adr_o,
    output logic                  ul_vld_o,
    output logic                  ur_vld_o,
    output logic                  bl_vld_o,
    output logic                  br_vld_o,
    output logic [TW-1:0]         pos_x_o,
    output logic [TW-1:0]         pos_y_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int c_w   = TILE_NUM_X * TILE_SIZ;
    localparam int c_h   = TILE_NUM_Y * TILE_SIZ;
    localparam int c_xw  = clog2_min1(c_w);
    localparam int c_yw  = clog2_min1(c_h);
    localparam int c_cw  = clog2_min1(TILE_NUM_X);
    localparam int c_rw  = clog2_min1(TILE_NUM_Y);
    localparam int c_tiw = AW - DAT_PIX_WD;

    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_state_nxt;
    logic [1:0]        r_drain_cnt;
    logic [c_xw-1:0]   r_x_cnt;
    logic [c_yw-1:0]   r_y_cnt;

    logic              w_acc;
    logic              w_start;
    logic              w_x_end;
    logic              w_y_end;
    logic              w_last;

    logic [c_cw-1:0]   w_col;
    logic [c_rw-1:0]   w_row;
    logic [TW-1:0]     w_pos_x;
    logic [TW-1:0]     w_pos_y;
    logic              w_pair_x;
    logic              w_pair_y;
    logic [c_tiw-1:0]  w_tile_ul;
    logic [c_tiw-1:0]  w_tile_ur;
    logic [c_tiw-1:0]  w_tile_bl;
    logic [c_tiw-1:0]  w_tile_br;

    logic              r_lut_rd;
    logic [AW-1:0]     r_ul_adr;
    logic [AW-1:0]     r_ur_adr;
    logic [AW-1:0]     r_bl_adr;
    logic [AW-1:0]     r_br_adr;
    logic [3:0]        r_s1_vld;   // {ul, ur, bl, br}
    logic [TW-1:0]     r_s1_pos_x;
    logic [TW-1:0]     r_s1_pos_y;
    logic [3:0]        r_s2_vld;
    logic [TW-1:0]     r_pos_x;
    logic [TW-1:0]     r_s2_pos_y;
    logic [TW-1:0]     r_pos_y;

    assign w_acc   = pix_vld_i & (r_state == c_st_run);
    assign w_start = start_i & (r_state == c_st_idle);
    assign w_x_end = (r_x_cnt == c_xw'(c_w - 1));
    assign w_y_end = (r_y_cnt == c_yw'(c_h - 1));
    assign w_last  = w_acc & w_x_end & w_y_end;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (start_i) w_state_nxt = c_st_run;
            c_st_run:   if (w_last) w_state_nxt = c_st_drain;
            c_st_drain: if (r_drain_cnt == 2'(c_drain_cyc - 1)) w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= 2'd0;
        end else if (r_state == c_st_drain) begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
        end else begin
            r_drain_cnt <= 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Raster coordinate counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else if (w_start) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else if (w_acc) begin
            if (w_x_end) begin
                r_x_cnt <= '0;
                r_y_cnt <= w_y_end ? '0 : r_y_cnt + 1'b1;
            end else begin
                r_x_cnt <= r_x_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Coordinate to tile mapping
    // ------------------------------------------------------------------
    che_cmf_axis_map #(
        .TILE_SIZ (TILE_SIZ),
        .TILE_NUM (TILE_NUM_X),
        .CW       (c_xw),
        .TIW      (c_cw),
        .TW       (TW)
    ) u_map_x (
        .i_coord    (r_x_cnt),
        .o_tile     (w_col),
        .o_off      (w_pos_x),
        .o_pair_vld (w_pair_x)
    );

    che_cmf_axis_map #(
        .TILE_SIZ (TILE_SIZ),
        .TILE_NUM (TILE_NUM_Y),
        .CW       (c_yw),
        .TIW      (c_rw),
        .TW       (TW)
    ) u_map_y (
        .i_coord    (r_y_cnt),
        .o_tile     (w_row),
        .o_off      (w_pos_y),
        .o_pair_vld (w_pair_y)
    );

    // Neighbour tiles: right is +1, down is +TILE_NUM_X in the linear index
    assign w_tile_ul = c_tiw'(w_row) * c_tiw'(TILE_NUM_X) + c_tiw'(w_col);
    assign w_tile_ur = w_tile_ul + c_tiw'(1);
    assign w_tile_bl = w_tile_ul + c_tiw'(TILE_NUM_X);
    assign w_tile_br = w_tile_bl + c_tiw'(1);

    // ------------------------------------------------------------------
    // Pipeline: n+1 LUT read, n+2 valids/pos_x, n+3 pos_y
    // Unused slots carry a zero address so the LUT bus is deterministic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lut_rd   <= 1'b0;
            r_ul_adr   <= '0;
            r_ur_adr   <= '0;
            r_bl_adr   <= '0;
            r_br_adr   <= '0;
            r_s1_vld   <= '0;
            r_s1_pos_x <= '0;
            r_s1_pos_y <= '0;
            r_s2_vld   <= '0;
            r_pos_x    <= '0;
            r_s2_pos_y <= '0;
            r_pos_y    <= '0;
        end else begin
            r_lut_rd   <= w_acc;
            r_ul_adr   <= w_acc ? {w_tile_ul, pix_dat_i} : '0;
            r_ur_adr   <= (w_acc & w_pair_x) ? {w_tile_ur, pix_dat_i} : '0;
            r_bl_adr   <= (w_acc & w_pair_y) ? {w_tile_bl, pix_dat_i} : '0;
            r_br_adr   <= (w_acc & w_pair_x & w_pair_y) ? {w_tile_br, pix_dat_i} : '0;
            r_s1_vld   <= {w_acc, w_acc & w_pair_x, w_acc & w_pair_y,
                           w_acc & w_pair_x & w_pair_y};
            r_s1_pos_x <= w_pos_x;
            r_s1_pos_y <= w_pos_y;
            r_s2_vld   <= r_s1_vld;
            r_pos_x    <= r_s1_pos_x;
            r_s2_pos_y <= r_s1_pos_y;
            // pos_y trails pos_x by one cycle: the interpolator samples it
            // in its second stage
            r_pos_y    <= r_s2_pos_y;
        end
    end

    assign pix_rdy_o    = (r_state == c_st_run);
    assign busy_o       = (r_state == c_st_run) | (r_state == c_st_drain);
    assign frame_done_o = (r_state == c_st_done);
    assign lut_rd_o     = r_lut_rd;
    assign lut_ul_adr_o = r_ul_adr;
    assign lut_ur_adr_o = r_ur_adr;
    assign lut_bl_adr_o = r_bl_adr;
    assign lut_br_adr_o = r_br_adr;
    assign ul_vld_o     = r_s2_vld[3];
    assign ur_vld_o     = r_s2_vld[2];
    assign bl_vld_o     = r_s2_vld[1];
    assign br_vld_o     = r_s2_vld[0];
    assign pos_x_o      = r_pos_x;
    assign pos_y_o      = r_pos_y;

endmodule
`default_nettype wire

// File: tb/tb_che_cmf_ipl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_che_cmf_ipl_ctrl
// Description : Self-checking bench for che_cmf_ipl_ctrl (256x256, 64-pixel
//               tiles). A behavioural model tracks accepted pixels and checks
//               every output each cycle; a vector table holds the hand-derived
//               corner/interior cases that are compared after the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_che_cmf_ipl_ctrl;

    localparam int c_tsz  = 64;
    localparam int c_nx   = 4;
    localparam int c_ny   = 4;
    localparam int c_w    = c_nx * c_tsz;
    localparam int c_h    = c_ny * c_tsz;
    localparam int c_npix = c_w * c_h;
    localparam int c_nvec = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        pix_vld_i = 1'b0;
    logic [7:0]  pix_dat_i = 8'h00;
    logic        pix_rdy_o, lut_rd_o, busy_o, frame_done_o;
    logic [11:0] lut_ul_adr_o, lut_ur_adr_o, lut_bl_adr_o, lut_br_adr_o;
    logic        ul_vld_o, ur_vld_o, bl_vld_o, br_vld_o;
    logic [5:0]  pos_x_o, pos_y_o;

    always #5 clk = ~clk;

    che_cmf_ipl_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .pix_vld_i    (pix_vld_i),
        .pix_dat_i    (pix_dat_i),
        .pix_rdy_o    (pix_rdy_o),
        .lut_rd_o     (lut_rd_o),
        .lut_ul_adr_o (lut_ul_adr_o),
        .lut_ur_adr_o (lut_ur_adr_o),
        .lut_bl_adr_o (lut_bl_adr_o),
        .lut_br_adr_o (lut_br_adr_o),
        .ul_vld_o     (ul_vld_o),
        .ur_vld_o     (ur_vld_o),
        .bl_vld_o     (bl_vld_o),
        .br_vld_o     (br_vld_o),
        .pos_x_o      (pos_x_o),
        .pos_y_o      (pos_y_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    typedef struct {
        int       x, y, dat;
        int       ul, ur, bl, br;
        bit [3:0] vld;   // {ul, ur, bl, br}
        int       px, py;
    } vec_t;

    typedef struct {
        bit acc;
        int x, y, dat;
        bit last;
        int tix;
    } pix_t;

    typedef struct {
        int       ul, ur, bl, br;
        bit [3:0] vld;
        int       px, py;
    } exp_t;

    vec_t     tbl [c_nvec];
    int       a_ul [c_nvec], a_ur [c_nvec], a_bl [c_nvec], a_br [c_nvec];
    int       a_px [c_nvec], a_py [c_nvec];
    bit [3:0] a_vld [c_nvec];
    bit       a_seen [c_nvec];

    pix_t hist [4];
    int   m_cnt = 0;
    bit   m_active = 0;
    bit   m_run = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_rd = 0;
    int   n_fd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int find(input int x, input int y);
        for (int i = 0; i < c_nvec; i++)
            if (tbl[i].x == x && tbl[i].y == y) return i;
        return -1;
    endfunction

    // Axis rule: half-tile border bands use the edge tile alone with zero
    // offset; elsewhere shift by half a tile and split into tile/offset.
    function automatic void axis(input int c, input int n, output int tile,
                                 output int off, output bit pair);
        int half;
        half = c_tsz / 2;
        if (c < half) begin
            tile = 0; off = 0; pair = 0;
        end else if (c >= n * c_tsz - half) begin
            tile = n - 1; off = 0; pair = 0;
        end else begin
            tile = (c - half) / c_tsz; off = (c - half) % c_tsz; pair = 1;
        end
    endfunction

    function automatic exp_t model(input pix_t p);
        exp_t e;
        int   col, row, px, py, t;
        bit   pxp, pyp;
        e = '{default: 0};
        if (!p.acc) return e;
        axis(p.x, c_nx, col, px, pxp);
        axis(p.y, c_ny, row, py, pyp);
        t     = row * c_nx + col;
        e.ul  = t * 256 + p.dat;
        e.ur  = pxp ? (t + 1) * 256 + p.dat : 0;
        e.bl  = pyp ? (t + c_nx) * 256 + p.dat : 0;
        e.br  = (pxp && pyp) ? (t + c_nx + 1) * 256 + p.dat : 0;
        e.vld = {1'b1, pxp, pyp, pxp & pyp};
        e.px  = px;
        e.py  = py;
        return e;
    endfunction

    task automatic clear_hist();
        for (int i = 0; i < 4; i++) begin
            hist[i] = '{default: 0};
            hist[i].tix = -1;
        end
    endtask

    // One clock: drive inputs, advance the model, check every output.
    task automatic step(input bit vld, input bit [7:0] dat, input bit start);
        bit   acc, fd;
        pix_t np;
        exp_t e0, e1, e2;
        pix_vld_i = vld;
        pix_dat_i = dat;
        start_i   = start;
        acc       = vld && m_run;
        @(posedge clk);
        #1;
        np = '{default: 0};
        np.tix = -1;
        if (acc) begin
            np.acc  = 1;
            np.x    = m_cnt % c_w;
            np.y    = m_cnt / c_w;
            np.dat  = int'(dat);
            np.last = (m_cnt == c_npix - 1);
            np.tix  = find(np.x, np.y);
            m_cnt++;
            if (m_cnt == c_npix) m_run = 0;
        end
        if (start && !m_active) begin
            m_active = 1; m_run = 1; m_cnt = 0;
        end
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = np;
        e0 = model(hist[0]);
        e1 = model(hist[1]);
        e2 = model(hist[2]);
        fd = hist[3].acc && hist[3].last;
        if (lut_rd_o) n_rd++;
        if (frame_done_o) n_fd++;
        chk("pix_rdy", pix_rdy_o, m_run);
        chk("lut_rd", lut_rd_o, hist[0].acc);
        chk("ul_adr", lut_ul_adr_o, e0.ul);
        chk("ur_adr", lut_ur_adr_o, e0.ur);
        chk("bl_adr", lut_bl_adr_o, e0.bl);
        chk("br_adr", lut_br_adr_o, e0.br);
        chk("vld", {ul_vld_o, ur_vld_o, bl_vld_o, br_vld_o}, e1.vld);
        if (hist[1].acc) chk("pos_x", pos_x_o, e1.px);
        if (hist[2].acc) chk("pos_y", pos_y_o, e2.py);
        chk("frame_done", frame_done_o, fd);
        chk("busy", busy_o, m_active && !fd);
        if (fd) m_active = 0;
        if (hist[0].acc && hist[0].tix >= 0) begin
            a_ul[hist[0].tix] = lut_ul_adr_o; a_ur[hist[0].tix] = lut_ur_adr_o;
            a_bl[hist[0].tix] = lut_bl_adr_o; a_br[hist[0].tix] = lut_br_adr_o;
        end
        if (hist[1].acc && hist[1].tix >= 0) begin
            a_vld[hist[1].tix] = {ul_vld_o, ur_vld_o, bl_vld_o, br_vld_o};
            a_px[hist[1].tix]  = pos_x_o;
        end
        if (hist[2].acc && hist[2].tix >= 0) begin
            a_py[hist[2].tix]   = pos_y_o;
            a_seen[hist[2].tix] = 1;
        end
    endtask

    // Feed pixels with occasional bubbles until n pixels of the frame are in
    task automatic feed_until(input int n, input int mid_start_at);
        int  cyc, ti;
        bit  v, s, sent;
        bit [7:0] d;
        cyc  = 0;
        sent = 0;
        while (m_run && m_cnt < n && cyc < 80000 && n_err < 200) begin
            v  = ($urandom_range(0, 31) != 0);
            ti = find(m_cnt % c_w, m_cnt / c_w);
            d  = (ti >= 0) ? 8'(tbl[ti].dat) : 8'($urandom);
            s  = 0;
            if (!sent && mid_start_at >= 0 && m_cnt >= mid_start_at) begin
                s = 1; sent = 1;
            end
            step(v, d, s);
            cyc++;
        end
        chk("feed_budget", cyc < 80000, 1'b1);
    endtask

    initial begin
        //          x    y    dat   ul     ur     bl     br     vld      px  py
        tbl[0] = '{  0,   0, 'h12, 'h012, 0,     0,     0,     4'b1000,  0, 0};
        tbl[1] = '{100,  40, 'hA0, 'h1A0, 'h2A0, 'h5A0, 'h6A0, 4'b1111,  4, 8};
        tbl[2] = '{255, 255, 'h5C, 'hF5C, 0,     0,     0,     4'b1000,  0, 0};
        tbl[3] = '{ 10, 100, 'h33, 'h433, 0,     'h833, 0,     4'b1010,  0, 4};
        tbl[4] = '{ 99,  40, 'h77, 'h177, 'h277, 'h577, 'h677, 4'b1111,  3, 8};
        tbl[5] = '{ 32,  32, 'h01, 'h001, 'h101, 'h401, 'h501, 4'b1111,  0, 0};
        tbl[6] = '{223,   0, 'hFF, 'h2FF, 'h3FF, 0,     0,     4'b1100, 63, 0};
        tbl[7] = '{224,   0, 'h80, 'h380, 0,     0,     0,     4'b1000,  0, 0};
        tbl[8] = '{ 31, 224, 'h44, 'hC44, 0,     0,     0,     4'b1000,  0, 0};
        for (int i = 0; i < c_nvec; i++) a_seen[i] = 0;
        clear_hist();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {pix_rdy_o, lut_rd_o, ul_vld_o, ur_vld_o, bl_vld_o,
                          br_vld_o, busy_o, frame_done_o}, 0);
        chk("rst_adrs", {lut_ul_adr_o, lut_ur_adr_o}, 0);
        chk("rst_adrs2", {lut_bl_adr_o, lut_br_adr_o}, 0);
        chk("rst_pos", {pos_x_o, pos_y_o}, 0);
        rst = 1'b0;

        // Pixels offered while idle must not be taken
        repeat (3) step(1'b1, 8'h5A, 1'b0);

        // Aborted frame: reset asynchronously after 1000 pixels
        step(1'b0, 8'h00, 1'b1);
        feed_until(1000, -1);
        #3 rst = 1'b1;
        #1;
        chk("abort_async", {pix_rdy_o, lut_rd_o, ul_vld_o, ur_vld_o, bl_vld_o,
                            br_vld_o, busy_o, frame_done_o}, 0);
        m_active = 0; m_run = 0; m_cnt = 0;
        clear_hist();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) step(1'b1, 8'h11, 1'b0);
        chk("abort_no_done", n_fd, 0);

        // Full frame with random data and bubbles; a start mid-run is ignored
        n_rd = 0;
        n_fd = 0;
        step(1'b0, 8'h00, 1'b1);
        feed_until(c_npix, 500);
        chk("frame_complete", m_run, 1'b0);
        repeat (8) step(1'b0, 8'h00, 1'b0);
        chk("rd_pulses", n_rd, c_npix);
        chk("done_pulses", n_fd, 1);
        chk("busy_end", busy_o, 1'b0);

        // Hand-derived vectors captured during the frame
        for (int i = 0; i < c_nvec; i++) begin
            chk($sformatf("tbl%0d_seen", i), a_seen[i], 1'b1);
            chk($sformatf("tbl%0d_ul", i), a_ul[i], tbl[i].ul);
            chk($sformatf("tbl%0d_ur", i), a_ur[i], tbl[i].ur);
            chk($sformatf("tbl%0d_bl", i), a_bl[i], tbl[i].bl);
            chk($sformatf("tbl%0d_br", i), a_br[i], tbl[i].br);
            chk($sformatf("tbl%0d_vld", i), a_vld[i], tbl[i].vld);
            chk($sformatf("tbl%0d_px", i), a_px[i], tbl[i].px);
            chk($sformatf("tbl%0d_py", i), a_py[i], tbl[i].py);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/che_cmf_ipl_ctrl.md
# che_cmf_ipl_ctrl

Pixel-stream sequencer for the CMF bilinear interpolator in the contrast-enhancement pipeline. Accepts a raster pixel stream, tracks pixel coordinates, and computes the tile indices, edge validity and in-tile offsets for each pixel. It issues the four tile-LUT reads for each pixel, then drives the interpolator's valid/position inputs aligned to the returning LUT data. It also reports frame progress.

## Interface
- `TILE_SIZ`, default 64: tile edge in pixels, power of two; `TW = LOG2(TILE_SIZ)`.
- `TILE_NUM_X`, default 4: tiles per row; image width `W = TILE_NUM_X*TILE_SIZ`.
- `TILE_NUM_Y`, default 4: tiles per column; image height `H = TILE_NUM_Y*TILE_SIZ`.
- `DAT_PIX_WD`, default 8: pixel width.
- `AW = LOG2(TILE_NUM_X*TILE_NUM_Y) + DAT_PIX_WD`: LUT address width, derived.
- `clk` in 1: single clock; all logic rises on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: one-cycle pulse that begins a frame; honoured only in IDLE.
- `pix_vld_i` in 1: input pixel valid.
- `pix_dat_i` in DAT_PIX_WD: input pixel value, raster order.
- `pix_rdy_o` out 1: high only in RUN; a pixel transfers when `pix_vld_i & pix_rdy_o`.
- `lut_rd_o` out 1: LUT read strobe, one per accepted pixel.
- `lut_ul_adr_o`, `lut_ur_adr_o`, `lut_bl_adr_o`, `lut_br_adr_o` out AW each: `{tile_idx, pix_dat}`, with `tile_idx = row*TILE_NUM_X + col`.
- `ul_vld_o`, `ur_vld_o`, `bl_vld_o`, `br_vld_o` out 1 each: interpolator valids, aligned with LUT read data.
- `pos_x_o` out TW: horizontal offset, aligned with the valids.
- `pos_y_o` out TW: vertical offset, one cycle after `pos_x_o`.
- `busy_o` out 1: high from `start_i` until `frame_done_o`.
- `frame_done_o` out 1: one-cycle pulse coincident with the interpolator output of the last pixel.

## Operation
- **FSM states.**
  - IDLE --start_i--> RUN.
  - RUN --(W*H-th pixel accepted)--> DRAIN.
  - DRAIN --(3 cycles)--> DONE.
  - DONE --(1 cycle, pulses frame_done_o)--> IDLE.
- **Coordinates.** `x_cnt` counts 0..W-1 and `y_cnt` counts 0..H-1, advancing per accepted pixel. `x_cnt` wraps to 0 and increments `y_cnt` at W-1. Both counters clear on `start_i`.
- **Horizontal mapping**, with `h = TILE_SIZ/2`:
  - `x < h`: col = 0, single column, `pos_x = 0`.
  - `x >= W-h`: col = TILE_NUM_X-1, single column, `pos_x = 0`.
  - Otherwise: `xs = x-h`, `col = xs>>TW`, `pos_x = xs[TW-1:0]`, two columns (col, col+1).
- **Vertical mapping**: identical rule on y, producing row and `pos_y`.
- **Single column.** The tile is always presented on the left slot (`ul`/`bl`), and `ur_vld_o`/`br_vld_o` are low. The interpolator ignores a lone right-hand valid.
- **Single row.** The tile is always presented on the up slot (`ul`/`ur`), and `bl_vld_o`/`br_vld_o` are low.
- **Address and valid rule.** Addresses for invalid slots are don't-care but must be driven to 0. The interpolator's internal flop widths are not this block's concern; `pos_*` never exceeds `TILE_SIZ-1`.
- **Ignored inputs.** `start_i` outside IDLE is ignored. `pix_vld_i` outside RUN is not accepted.
- **Reset.** `rst` at any time, including mid-frame, returns the FSM to IDLE and clears the counters and all pipeline valids. No `frame_done_o` is produced for an aborted frame.

## Timing
- **Reset values.** All outputs are 0 in reset, so `pix_rdy_o=0` and `busy_o=0`.
- **Pipeline**, for a pixel accepted at cycle n:
  - n+1: `lut_rd_o` and addresses (registered).
  - n+2: LUT data is available (1-cycle synchronous RAM); `*_vld_o` and `pos_x_o` are driven.
  - n+3: `pos_y_o` is driven. The interpolator samples `pos_y` in its second stage.
  - n+4: interpolator output.
- **Frame done.** `frame_done_o` fires at n+4 of the last pixel.
- **Throughput.** One pixel per cycle, no internal stall; gaps in `pix_vld_i` propagate as bubbles.
- **Busy.** `busy_o` rises the cycle after `start_i` and falls with `frame_done_o`.

## Structure
- **Shared include/package.** `TILE_SIZ`, `DAT_PIX_WD`, the `LOG2` macro, `TILE_NUM_X/Y`, and the FSM state encodings (IDLE/RUN/DRAIN/DONE).
- **Sub-module `che_cmf_axis_map`.** Instanced twice (x and y). It maps coordinate → {tile, offset, pair_vld}, is combinational, and is parameterised by `TILE_SIZ` and tile count.
- **Top level.** FSM, counters, address register stage, and the valid/`pos_x`/`pos_y` delay lines.

## Test plan
Defaults throughout: 256×256 image, TILE_SIZ=64.
- **Top-left corner.** Pixel (0,0) with value 0x12 → `ul_adr={0,0x12}`, `ul_vld` only, `pos_x=pos_y=0`.
- **Interior pixel.** Pixel (100,40) with value 0xA0 → tiles ul=1, ur=2, bl=5, br=6; all four valids; `pos_x=4`, `pos_y=8`.
- **Bottom-right corner.** Pixel (255,255) → `ul` only, tile 15.
- **Edge slot placement.**
  - Pixel (10,100) → `ul`=tile 4, `bl`=tile 8, `ur`/`br` low, `pos_y=4`.
- **Position alignment.** Back-to-back pixels (99,40) then (100,40) → `pos_x_o` is 3,4 at n+2,n+3 and `pos_y_o` is 8,8 at n+3,n+4.
- **Full frame.**
  - 65536 pixels → exactly 65536 `lut_rd_o` pulses, then `frame_done_o` 4 cycles after the last accept and `busy_o` falls.
  - A `start_i` during RUN is ignored.
  - `rst` at pixel 1000 → IDLE, no `frame_done_o`, and the next frame restarts at (0,0).
